// File: rtl/arb_egress_stage_onehot_select.sv
// onehot_select: grant vector to lowest set index, multi-hot flag and selected data slice
`include "utils.sv"
module onehot_select #(
  parameter int NUM_REQS = 4,
  parameter int WIDTH = 8,
  parameter int SIDW = `SIDW_OF(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0]       i_gnt,
  input  logic [NUM_REQS*WIDTH-1:0] i_flat_data,
  output logic [SIDW-1:0]           o_idx,
  output logic                      o_multi_hot,
  output logic [WIDTH-1:0]          o_data
);
  // descending scan so the lowest set bit wins
  always_comb begin
    o_idx = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) if (i_gnt[i]) o_idx = SIDW'(i);
  end
  assign o_multi_hot = |(i_gnt & (i_gnt - NUM_REQS'(1)));
  assign o_data = `FLAT_SLICE(i_flat_data, o_idx, WIDTH);
endmodule

// File: rtl/utils.sv
// utils: shared width derivation and flat-vector slicing macros
`ifndef UTILS
`define UTILS
`define SIDW_OF(n) (((n) > 1) ? $clog2(n) : 1)
`define FLAT_SLICE(v, i, w) v[(i)*(w) +: (w)]
`endif

// File: rtl/arb_egress_stage.sv
// arb_egress_stage: captures the granted FIFO head word into a skid buffer and drains it
// over valid/ready, asserting blk back to the arbiter while the buffer is full.
`include "utils.sv"
module arb_egress_stage #(
  parameter int NUM_REQS = 4,
  parameter int WIDTH = 8,
  parameter int SKID_DEPTH = 2,
  parameter int CNTW = 16,
  localparam int SIDW = `SIDW_OF(NUM_REQS),
  localparam int PTRW = $clog2(SKID_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQS-1:0]       gnt,
  input  logic [NUM_REQS*WIDTH-1:0] flat_data_in,
  output logic                      blk,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic [WIDTH-1:0]          out_data,
  output logic [SIDW-1:0]           out_src,
  output logic [CNTW-1:0]           pkt_cnt,
  output logic                      ovf_err,
  output logic                      gnt_err
);
  localparam logic [PTRW:0] FULL = (PTRW + 1)'(SKID_DEPTH);
  logic [SIDW-1:0]  r_src [SKID_DEPTH];
  logic [WIDTH-1:0] r_data [SKID_DEPTH];
  logic [PTRW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [PTRW:0]    r_occ;
  logic [CNTW-1:0]  r_pkt_cnt;
  logic             r_ovf, r_gnt_err;
  logic [SIDW-1:0]  w_idx;
  logic [WIDTH-1:0] w_sel;
  logic             w_multi, w_push, w_pop, w_full, w_wr;
  onehot_select #(.NUM_REQS(NUM_REQS), .WIDTH(WIDTH), .SIDW(SIDW)) u_sel (
    .i_gnt(gnt),
    .i_flat_data(flat_data_in),
    .o_idx(w_idx),
    .o_multi_hot(w_multi),
    .o_data(w_sel)
  );
  assign w_push = |gnt;
  assign w_full = r_occ == FULL;
  assign w_wr = w_push & ~w_full;
  assign w_pop = out_vld & out_rdy;
  // pop only sees entries written on earlier cycles, so there is no same-cycle bypass
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ <= '0;
      r_pkt_cnt <= '0;
      r_ovf <= 1'b0;
      r_gnt_err <= 1'b0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        r_src[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_wr) begin
        r_src[r_wr_ptr] <= w_idx;
        r_data[r_wr_ptr] <= w_sel;
        r_wr_ptr <= r_wr_ptr + PTRW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTRW'(1);
        r_pkt_cnt <= r_pkt_cnt + CNTW'(1);
      end
      r_occ <= r_occ + (PTRW + 1)'(w_wr) - (PTRW + 1)'(w_pop);
      if (w_push && w_full) r_ovf <= 1'b1;
      if (w_multi) r_gnt_err <= 1'b1;
    end
  end
  assign out_vld = r_occ != '0;
  assign blk = w_full;
  assign out_data = r_data[r_rd_ptr];
  assign out_src = r_src[r_rd_ptr];
  assign pkt_cnt = r_pkt_cnt;
  assign ovf_err = r_ovf;
  assign gnt_err = r_gnt_err;
`ifdef FORMAL
  always_comb if (blk) assume (gnt == '0);
  always_ff @(posedge clk) begin
    assert (!ovf_err);
    assert (r_occ <= FULL);
  end
  always_ff @(posedge clk) if (!rst && $past(!rst && out_vld && !out_rdy)) assert ($stable(out_data));
`endif
endmodule
